cc_muxn_scan_sequencer: RTL and testbench
=========================================

Name: cc_muxn_scan_sequencer

Overview:
Parametrised N-channel, DATAWIDTH-wide registered multiplexer with two modes: manual select and automatic round-robin scan with a valid/ready output handshake. It is the next-generation replacement for the fixed 8:1 combinational selector. It feeds serialised channel data to downstream display and UART blocks. Out-of-range selects are rejected and flagged instead of silently held.

Parameters:
NUM_CHANNELS, 8, number of input channels; legal range 2..2^SELECTWIDTH.
DATAWIDTH, 8, width of each channel word.
SELECTWIDTH, 3, width of select and channel-index buses; must be >= clog2(NUM_CHANNELS).
DWELL_CYCLES, 4, clock cycles spent on each channel before sampling in scan mode; must be >= 1.

Ports:
CC_MUXSEQ_CLOCK_50  in  1  system clock; all state changes on the rising edge.
CC_MUXSEQ_RESET_InLow  in  1  reset; synchronous, active-low.
CC_MUXSEQ_mode_In  in  1  0 = manual, 1 = scan.
CC_MUXSEQ_enable_In  in  1  scan run enable.
CC_MUXSEQ_select_InBUS  in  SELECTWIDTH  manual channel request.
CC_MUXSEQ_selectLoad_In  in  1  strobe that loads select_InBUS.
CC_MUXSEQ_data_InBUS  in  NUM_CHANNELS*DATAWIDTH  packed channels; channel k occupies bits [k*DATAWIDTH +: DATAWIDTH].
CC_MUXSEQ_ready_In  in  1  downstream accept (scan mode only).
CC_MUXSEQ_z_OutBUS  out  DATAWIDTH  registered selected data.
CC_MUXSEQ_channel_OutBUS  out  SELECTWIDTH  index of the channel currently on z.
CC_MUXSEQ_valid_Out  out  1  z is valid.
CC_MUXSEQ_frameDone_Out  out  1  one-cycle pulse when the last channel is accepted in scan mode.
CC_MUXSEQ_selError_Out  out  1  one-cycle pulse when an out-of-range select load is rejected.

Behaviour:
- Reset (RESET_InLow=0 at an edge) clears the following: z=0, channel=0, valid=0, frameDone=0, selError=0. Internal registers also clear: manSel=0, scanPtr=0, dwell counter=0, state=IDLE. Reset overrides all other inputs, including mid-handshake.
- Select load is accepted in every state.
  - If selectLoad=1 and select<NUM_CHANNELS: manSel<=select.
  - If select>=NUM_CHANNELS: manSel unchanged and selError=1 for the next cycle only.
- States: IDLE, MANUAL, DWELL, PRESENT.
- IDLE: valid=0.
  - mode=0 -> MANUAL.
  - mode=1 and enable=1 -> DWELL, counter<=DWELL_CYCLES-1.
  - Otherwise stay in IDLE.
- MANUAL: on every edge, z<=data[manSel], channel<=manSel, valid<=1. ready_In is ignored.
  - A new select is visible on z two edges after the load is sampled.
  - mode=1 -> IDLE with valid<=0; z and channel hold their values.
- DWELL: if counter!=0, decrement.
  - When counter==0: z<=data[scanPtr], channel<=scanPtr, valid<=1 -> PRESENT.
  - If mode=0 or enable=0 during DWELL -> IDLE; no sample is taken and scanPtr is unchanged.
- PRESENT: z, channel and valid=1 hold stable until valid&ready. Mode and enable changes are ignored until the handshake completes.
  - On acceptance: valid<=0. If scanPtr==NUM_CHANNELS-1, then scanPtr<=0 and frameDone=1 for one cycle; otherwise scanPtr<=scanPtr+1.
  - Next state: DWELL (counter reloaded) if mode=1 and enable=1, else IDLE.
- Scan timing: the first valid asserts DWELL_CYCLES+1 edges after IDLE sees enable=1. Each subsequent channel takes DWELL_CYCLES+1 edges after acceptance when ready is held high.
- scanPtr persists across IDLE and MANUAL, so scan resumes at the next unvisited channel. Only reset returns it to 0.
- Simultaneous selectLoad and scan activity are independent; manSel never affects scanPtr.

Test Plan:
- Reset with inputs active -> all outputs 0. After release with mode=0, manSel=0: valid=1 and z=data[0] on the second edge.
- N=8, DW=8, channel k = 8'h10+k, mode=0. Load select=5 -> z=8'h15, channel=5 two edges after the load.
- N=6, SW=3. Load select=7 -> selError pulses for exactly one cycle, and z stays at the previous channel's data.
- Scan, DWELL_CYCLES=4, ready=1 -> channels 0..7 emitted every 5 cycles. frameDone pulses on acceptance of channel 7, and the pointer wraps to 0.
- Scan with ready=0 held for 10 cycles in PRESENT on channel 3, with mode toggled to 0 mid-hold -> z=8'h13, channel=3 and valid remain stable. After ready=1 the block goes to IDLE, then MANUAL.
- Reset asserted while in PRESENT -> outputs clear on that edge. The next scan starts from channel 0.

Source files
------------

// File: rtl/cc_muxn_scan_sequencer_if.sv
// Bus bundle for cc_muxn_scan_sequencer.
//   master : the side that drives mode/enable/select/data/ready and consumes
//            z/channel/valid/frameDone/selError (testbench or upstream logic).
//   slave  : the sequencer itself.
interface cc_muxn_scan_sequencer_if #(
    parameter int NUM_CHANNELS = 8,
    parameter int DATAWIDTH    = 8,
    parameter int SELECTWIDTH  = 3
);
    logic                              CC_MUXSEQ_mode_In;
    logic                              CC_MUXSEQ_enable_In;
    logic [SELECTWIDTH-1:0]            CC_MUXSEQ_select_InBUS;
    logic                              CC_MUXSEQ_selectLoad_In;
    logic [NUM_CHANNELS*DATAWIDTH-1:0] CC_MUXSEQ_data_InBUS;
    logic                              CC_MUXSEQ_ready_In;
    logic [DATAWIDTH-1:0]              CC_MUXSEQ_z_OutBUS;
    logic [SELECTWIDTH-1:0]            CC_MUXSEQ_channel_OutBUS;
    logic                              CC_MUXSEQ_valid_Out;
    logic                              CC_MUXSEQ_frameDone_Out;
    logic                              CC_MUXSEQ_selError_Out;

    modport master (
        output CC_MUXSEQ_mode_In, CC_MUXSEQ_enable_In, CC_MUXSEQ_select_InBUS,
               CC_MUXSEQ_selectLoad_In, CC_MUXSEQ_data_InBUS, CC_MUXSEQ_ready_In,
        input  CC_MUXSEQ_z_OutBUS, CC_MUXSEQ_channel_OutBUS, CC_MUXSEQ_valid_Out,
               CC_MUXSEQ_frameDone_Out, CC_MUXSEQ_selError_Out
    );

    modport slave (
        input  CC_MUXSEQ_mode_In, CC_MUXSEQ_enable_In, CC_MUXSEQ_select_InBUS,
               CC_MUXSEQ_selectLoad_In, CC_MUXSEQ_data_InBUS, CC_MUXSEQ_ready_In,
        output CC_MUXSEQ_z_OutBUS, CC_MUXSEQ_channel_OutBUS, CC_MUXSEQ_valid_Out,
               CC_MUXSEQ_frameDone_Out, CC_MUXSEQ_selError_Out
    );
endinterface

// File: rtl/cc_muxn_scan_sequencer.sv
// N-channel registered multiplexer with manual select and round-robin scan.
//   CC_MUXSEQ_CLOCK_50     : clock, rising edge
//   CC_MUXSEQ_RESET_InLow  : synchronous active-low reset
//   bus (slave)            : mode/enable/select/selectLoad/data/ready in,
//                            z/channel/valid/frameDone/selError out
// Manual mode re-registers data[manSel] every cycle. Scan mode dwells
// DWELL_CYCLES on each channel, samples it, and holds it under valid until
// ready, then advances the scan pointer (wrapping with a frameDone pulse).
module cc_muxn_scan_sequencer #(
    parameter int NUM_CHANNELS = 8,
    parameter int DATAWIDTH    = 8,
    parameter int SELECTWIDTH  = 3,
    parameter int DWELL_CYCLES = 4
) (
    input logic                     CC_MUXSEQ_CLOCK_50,
    input logic                     CC_MUXSEQ_RESET_InLow,
    cc_muxn_scan_sequencer_if.slave bus
);
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SELECTWIDTH:0]   NUM_CH_EXT   = (SELECTWIDTH+1)'(NUM_CHANNELS);
    localparam logic [SELECTWIDTH-1:0] LAST_CH      = SELECTWIDTH'(NUM_CHANNELS - 1);
    localparam int SEL_SPAN = 2 ** SELECTWIDTH;

    typedef enum logic [1:0] {IDLE, MANUAL, DWELL, PRESENT} state_t;

    logic clk, rstN;
    logic mode, enable, selectLoad, ready, scanRun;
    logic [SELECTWIDTH-1:0] select;

    assign clk        = CC_MUXSEQ_CLOCK_50;
    assign rstN       = CC_MUXSEQ_RESET_InLow;
    assign mode       = bus.CC_MUXSEQ_mode_In;
    assign enable     = bus.CC_MUXSEQ_enable_In;
    assign selectLoad = bus.CC_MUXSEQ_selectLoad_In;
    assign select     = bus.CC_MUXSEQ_select_InBUS;
    assign ready      = bus.CC_MUXSEQ_ready_In;
    assign scanRun    = mode & enable;

    // Channel table padded to the full select span so any select-width
    // index stays in range; padding entries are never selected.
    logic [DATAWIDTH-1:0] chan [SEL_SPAN];
    for (genvar k = 0; k < SEL_SPAN; k++) begin : gChan
        if (k < NUM_CHANNELS) begin : gReal
            assign chan[k] = bus.CC_MUXSEQ_data_InBUS[k*DATAWIDTH +: DATAWIDTH];
        end else begin : gPad
            assign chan[k] = '0;
        end
    end

    state_t                 state, stateNext;
    logic [CNT_W-1:0]       dwellCnt, dwellCntNext;
    logic [SELECTWIDTH-1:0] manSel, scanPtr, scanPtrNext;
    logic [DATAWIDTH-1:0]   zReg, zNext;
    logic [SELECTWIDTH-1:0] channelReg, channelNext;
    logic                   validReg, validNext;
    logic                   frameDoneReg, frameDoneNext;
    logic                   selErrorReg;

    // State register
    always_ff @(posedge clk) begin
        if (!rstN) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (!mode)        stateNext = MANUAL;
                else if (enable)  stateNext = DWELL;
            end
            MANUAL: begin
                if (mode) stateNext = IDLE;
            end
            DWELL: begin
                // Abort wins over the final dwell tick: no sample is taken.
                if (!scanRun)            stateNext = IDLE;
                else if (dwellCnt == '0) stateNext = PRESENT;
            end
            PRESENT: begin
                // valid is always high here, so ready alone completes it.
                if (ready) stateNext = scanRun ? DWELL : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        zNext         = zReg;
        channelNext   = channelReg;
        validNext     = validReg;
        frameDoneNext = 1'b0;
        scanPtrNext   = scanPtr;
        dwellCntNext  = dwellCnt;
        unique case (state)
            IDLE: begin
                validNext = 1'b0;
                if (scanRun) dwellCntNext = DWELL_RELOAD;
            end
            MANUAL: begin
                if (!mode) begin
                    zNext       = chan[manSel];
                    channelNext = manSel;
                    validNext   = 1'b1;
                end else begin
                    validNext   = 1'b0;
                end
            end
            DWELL: begin
                if (scanRun) begin
                    if (dwellCnt != '0) begin
                        dwellCntNext = dwellCnt - 1'b1;
                    end else begin
                        zNext       = chan[scanPtr];
                        channelNext = scanPtr;
                        validNext   = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (ready) begin
                    validNext = 1'b0;
                    if (scanPtr == LAST_CH) begin
                        scanPtrNext   = '0;
                        frameDoneNext = 1'b1;
                    end else begin
                        scanPtrNext   = scanPtr + 1'b1;
                    end
                    if (scanRun) dwellCntNext = DWELL_RELOAD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            zReg         <= '0;
            channelReg   <= '0;
            validReg     <= 1'b0;
            frameDoneReg <= 1'b0;
            scanPtr      <= '0;
            dwellCnt     <= '0;
        end else begin
            zReg         <= zNext;
            channelReg   <= channelNext;
            validReg     <= validNext;
            frameDoneReg <= frameDoneNext;
            scanPtr      <= scanPtrNext;
            dwellCnt     <= dwellCntNext;
        end
    end

    // Manual select load runs in every state, independent of the scan path.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            manSel      <= '0;
            selErrorReg <= 1'b0;
        end else begin
            selErrorReg <= 1'b0;
            if (selectLoad) begin
                if ({1'b0, select} < NUM_CH_EXT) manSel      <= select;
                else                             selErrorReg <= 1'b1;
            end
        end
    end

    assign bus.CC_MUXSEQ_z_OutBUS       = zReg;
    assign bus.CC_MUXSEQ_channel_OutBUS = channelReg;
    assign bus.CC_MUXSEQ_valid_Out      = validReg;
    assign bus.CC_MUXSEQ_frameDone_Out  = frameDoneReg;
    assign bus.CC_MUXSEQ_selError_Out   = selErrorReg;
endmodule

// File: tb/tb_cc_muxn_scan_sequencer.sv
// Bench for cc_muxn_scan_sequencer: an 8-channel instance for manual/scan
// behaviour and a 6-channel instance for out-of-range select rejection.
module tb_cc_muxn_scan_sequencer;
    localparam int N = 8, DW = 8, SW = 3, D = 4;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    cc_muxn_scan_sequencer_if #(.NUM_CHANNELS(N), .DATAWIDTH(DW), .SELECTWIDTH(SW)) bus ();
    cc_muxn_scan_sequencer_if #(.NUM_CHANNELS(6), .DATAWIDTH(DW), .SELECTWIDTH(SW)) bus6 ();

    cc_muxn_scan_sequencer #(.NUM_CHANNELS(N), .DATAWIDTH(DW), .SELECTWIDTH(SW), .DWELL_CYCLES(D)) dut (
        .CC_MUXSEQ_CLOCK_50(clk), .CC_MUXSEQ_RESET_InLow(rstN), .bus(bus));
    cc_muxn_scan_sequencer #(.NUM_CHANNELS(6), .DATAWIDTH(DW), .SELECTWIDTH(SW), .DWELL_CYCLES(D)) dut6 (
        .CC_MUXSEQ_CLOCK_50(clk), .CC_MUXSEQ_RESET_InLow(rstN), .bus(bus6));

    // stimulus for the 8-channel instance
    logic mode, enable, selLoad, ready;
    logic [SW-1:0] sel;
    logic [N*DW-1:0] data;
    assign bus.CC_MUXSEQ_mode_In       = mode;
    assign bus.CC_MUXSEQ_enable_In     = enable;
    assign bus.CC_MUXSEQ_selectLoad_In = selLoad;
    assign bus.CC_MUXSEQ_select_InBUS  = sel;
    assign bus.CC_MUXSEQ_data_InBUS    = data;
    assign bus.CC_MUXSEQ_ready_In      = ready;
    logic [DW-1:0] z;  logic [SW-1:0] ch;  logic valid, fd, se;
    assign z     = bus.CC_MUXSEQ_z_OutBUS;
    assign ch    = bus.CC_MUXSEQ_channel_OutBUS;
    assign valid = bus.CC_MUXSEQ_valid_Out;
    assign fd    = bus.CC_MUXSEQ_frameDone_Out;
    assign se    = bus.CC_MUXSEQ_selError_Out;

    // stimulus for the 6-channel instance (always manual)
    logic selLoad6;
    logic [SW-1:0] sel6;
    logic [6*DW-1:0] data6;
    assign bus6.CC_MUXSEQ_mode_In       = 1'b0;
    assign bus6.CC_MUXSEQ_enable_In     = 1'b0;
    assign bus6.CC_MUXSEQ_selectLoad_In = selLoad6;
    assign bus6.CC_MUXSEQ_select_InBUS  = sel6;
    assign bus6.CC_MUXSEQ_data_InBUS    = data6;
    assign bus6.CC_MUXSEQ_ready_In      = 1'b0;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scan scoreboard: expPtr is the next channel that must be presented,
    // gap counts edges since the last acceptance (or since scan entry).
    int expPtr, gap, manModel;
    logic [N*DW-1:0] fixedData;

    task automatic scanCycles(input int n, input bit randReady);
        for (int i = 0; i < n; i++) begin
            logic v0, r;
            logic [DW-1:0] z0;
            logic [SW-1:0] c0;
            v0 = valid; z0 = z; c0 = ch;
            r = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            ready = r;
            step();
            if (v0 && r) begin
                chk("scan_accept_valid", valid, 0);
                chk("scan_frameDone", fd, (c0 == SW'(N - 1)));
                expPtr = (int'(c0) + 1) % N;
                gap = 0;
            end else if (v0) begin
                chk("scan_hold_valid", valid, 1);
                chk("scan_hold_ch", ch, c0);
                chk("scan_hold_z", z, z0);
                chk("scan_hold_fd", fd, 0);
            end else begin
                gap++;
                chk("scan_fd_quiet", fd, 0);
                chk("scan_valid_timing", valid, (gap == D));
                if (gap == D) begin
                    chk("scan_ch", ch, expPtr);
                    chk("scan_z", z, fixedData[expPtr*DW +: DW]);
                end
            end
        end
    endtask

    typedef struct {
        logic mode, enable, selLoad;
        logic [SW-1:0] sel;
        logic [DW-1:0] expZ;
        logic [SW-1:0] expCh;
        logic expValid;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int cyc;
        for (int k = 0; k < N; k++) fixedData[k*DW +: DW] = DW'(8'h10 + k);
        for (int k = 0; k < 6; k++) data6[k*DW +: DW] = DW'(8'hA0 + k);

        // manual-mode vectors, starting at reset release
        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 3'd0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 3'd5, 8'h10, 3'd0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h15, 3'd5, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd2, 8'h15, 3'd5, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h12, 3'd2, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h12, 3'd2, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h12, 3'd2, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h12, 3'd2, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h12, 3'd2, 1'b1};

        // reset with inputs active
        data = fixedData;
        mode = 1'b1; enable = 1'b1; selLoad = 1'b1; sel = 3'd5; ready = 1'b1;
        selLoad6 = 1'b1; sel6 = 3'd7;
        rstN = 1'b0;
        repeat (3) step();
        chk("rst_z", z, 0);   chk("rst_ch", ch, 0); chk("rst_valid", valid, 0);
        chk("rst_fd", fd, 0); chk("rst_se", se, 0);
        chk("rst6_se", bus6.CC_MUXSEQ_selError_Out, 0);
        chk("rst6_valid", bus6.CC_MUXSEQ_valid_Out, 0);

        // table-driven manual sequence
        rstN = 1'b1; ready = 1'b0; selLoad6 = 1'b0; sel6 = 3'd0;
        for (int i = 0; i < 10; i++) begin
            mode = vecs[i].mode; enable = vecs[i].enable;
            selLoad = vecs[i].selLoad; sel = vecs[i].sel;
            step();
            chk($sformatf("vec%0d_z", i), z, vecs[i].expZ);
            chk($sformatf("vec%0d_ch", i), ch, vecs[i].expCh);
            chk($sformatf("vec%0d_valid", i), valid, vecs[i].expValid);
            chk($sformatf("vec%0d_se", i), se, 0);
            chk($sformatf("vec%0d_fd", i), fd, 0);
        end
        selLoad = 1'b0;
        manModel = 2;

        // 6-channel instance: legal load, then rejected loads
        chk("n6_init_z", bus6.CC_MUXSEQ_z_OutBUS, 8'hA0);
        selLoad6 = 1'b1; sel6 = 3'd4; step();
        selLoad6 = 1'b0; step();
        chk("n6_load4_z", bus6.CC_MUXSEQ_z_OutBUS, 8'hA4);
        chk("n6_load4_se", bus6.CC_MUXSEQ_selError_Out, 0);
        for (int s = 6; s < 8; s++) begin
            selLoad6 = 1'b1; sel6 = SW'(s); step();
            chk($sformatf("n6_bad%0d_se_pulse", s), bus6.CC_MUXSEQ_selError_Out, 1);
            selLoad6 = 1'b0; step();
            chk($sformatf("n6_bad%0d_se_clear", s), bus6.CC_MUXSEQ_selError_Out, 0);
            chk($sformatf("n6_bad%0d_z", s), bus6.CC_MUXSEQ_z_OutBUS, 8'hA4);
            chk($sformatf("n6_bad%0d_ch", s), bus6.CC_MUXSEQ_channel_OutBUS, 4);
        end

        // random manual traffic: z shows this edge's data at the select
        // that was in force before the edge
        for (int i = 0; i < 60; i++) begin
            logic [N*DW-1:0] d;
            logic ld;
            logic [SW-1:0] s;
            for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'($urandom);
            ld = 1'($urandom_range(0, 1));
            s = SW'($urandom_range(0, N - 1));
            data = d; selLoad = ld; sel = s;
            step();
            chk("rman_z", z, d[manModel*DW +: DW]);
            chk("rman_ch", ch, manModel);
            chk("rman_valid", valid, 1);
            if (ld) manModel = int'(s);
        end
        selLoad = 1'b0; data = fixedData;

        // scan entry: MANUAL -> IDLE -> DWELL, then a full frame with ready=1
        mode = 1'b1; enable = 1'b1; ready = 1'b1;
        step(); chk("scan_entry_idle", valid, 0);
        step(); chk("scan_entry_dwell", valid, 0);
        expPtr = 0; gap = 0;
        scanCycles(5 * N + 6, 1'b0);
        scanCycles(200, 1'b1);

        // stall on channel 3 in PRESENT, toggle mode mid-hold
        rstN = 1'b0; step(); rstN = 1'b1;
        manModel = 0;
        step();  // IDLE -> DWELL
        cyc = 0;
        while (!(valid && ch == 3'd3) && cyc < 60) begin
            ready = 1'b1; step(); cyc++;
        end
        chk("reach_ch3_in_budget", (cyc < 60), 1);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) mode = 1'b0;
            step();
            chk("hold3_z", z, 8'h13); chk("hold3_ch", ch, 3); chk("hold3_valid", valid, 1);
        end
        ready = 1'b1; step();
        chk("rel3_valid", valid, 0); chk("rel3_fd", fd, 0);
        step(); chk("rel3_idle_valid", valid, 0);
        step();
        chk("rel3_manual_valid", valid, 1);
        chk("rel3_manual_z", z, fixedData[manModel*DW +: DW]);
        chk("rel3_manual_ch", ch, manModel);

        // reset while PRESENT on channel 4, then scan restarts at 0
        mode = 1'b1; enable = 1'b1; ready = 1'b0;
        step(); step();
        repeat (D) step();
        chk("pres4_valid", valid, 1); chk("pres4_ch", ch, 4); chk("pres4_z", z, 8'h14);
        rstN = 1'b0; step();
        chk("rstp_z", z, 0); chk("rstp_ch", ch, 0); chk("rstp_valid", valid, 0);
        chk("rstp_fd", fd, 0); chk("rstp_se", se, 0);
        rstN = 1'b1; step();
        repeat (D - 1) step();
        chk("restart_not_yet", valid, 0);
        step();
        chk("restart_valid", valid, 1); chk("restart_ch", ch, 0); chk("restart_z", z, 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
